shift_frame_arbiter: RTL

SHIFT_FRAME_ARBITER -- requirements
Module: shift_frame_arbiter

---
 rtl/shift_frame_arbiter_if.sv | 26 ++
 rtl/shift_frame_arbiter.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/shift_frame_arbiter_if.sv
// Requester handshake and serial-output bundle for shift_frame_arbiter.
// The arbiter takes the slave view; whatever feeds it takes the master view.
interface shift_frame_arbiter_if #(
  parameter int WIDTH = 8
) ();
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;
  logic             ser_out;
  logic             ser_valid;
  logic             ser_owner;
  logic             frame_done;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready, ser_out, ser_valid, ser_owner, frame_done
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready, ser_out, ser_valid, ser_owner, frame_done
  );
endinterface

// File: rtl/shift_frame_arbiter.sv
// Two-requester round-robin arbiter that serialises one WIDTH-bit word per grant,
// MSB first, followed by IDLE_GAP quiet cycles before the next grant.
module shift_frame_arbiter #(
  parameter int WIDTH    = 8,
  parameter int IDLE_GAP = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  shift_frame_arbiter_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam int GW = 4;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PEN_BIT  = CW'(WIDTH - 2);
  localparam logic [GW-1:0] LAST_GAP = GW'(IDLE_GAP - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] shift_reg;
  logic [CW-1:0]    bit_cnt_reg;
  logic [GW-1:0]    gap_cnt_reg;
  logic             last_reg;
  logic             prev_last_reg;
  logic             owner_reg;
  logic             ser_valid_reg;
  logic             done_reg;

  logic [1:0]       valid_vec;
  logic [1:0]       ready_vec;
  logic             grant;
  logic             handshake;
  logic [WIDTH-1:0] grant_data;

  assign valid_vec = {bus.req1_valid, bus.req0_valid};

  // A lone requester always wins; a contest goes to whoever was not served last.
  always_comb begin
    grant = 1'b0;
    if (valid_vec == 2'b11) begin
      grant = ~last_reg;
    end else if (valid_vec[1]) begin
      grant = 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = rst_n & ~flush & (state_reg == IDLE)
                           & valid_vec[gi] & (grant == 1'(gi));
    end
  endgenerate

  assign handshake  = |ready_vec;
  assign grant_data = grant ? bus.req1_data : bus.req0_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      last_reg      <= 1'b1;
      prev_last_reg <= 1'b1;
      owner_reg     <= 1'b0;
      ser_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
    end else if (flush) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      gap_cnt_reg   <= '0;
      ser_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      // An aborted frame was never delivered, so it must not cost its owner a turn.
      if (state_reg == SHIFT) begin
        last_reg <= prev_last_reg;
      end
    end else begin
      case (state_reg)
        IDLE: begin
          if (handshake) begin
            shift_reg     <= grant_data;
            bit_cnt_reg   <= '0;
            owner_reg     <= grant;
            prev_last_reg <= last_reg;
            last_reg      <= grant;
            ser_valid_reg <= 1'b1;
            done_reg      <= 1'b0;
            state_reg     <= SHIFT;
          end
        end
        SHIFT: begin
          shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
          if (bit_cnt_reg == LAST_BIT) begin
            bit_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            ser_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            state_reg     <= (IDLE_GAP == 0) ? IDLE : GAP;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CW'(1);
            // Pre-decode so the pulse is a flop that lines up with the last bit.
            done_reg    <= (bit_cnt_reg == PEN_BIT);
          end
        end
        GAP: begin
          if (gap_cnt_reg == LAST_GAP) begin
            gap_cnt_reg <= '0;
            state_reg   <= IDLE;
          end else begin
            gap_cnt_reg <= gap_cnt_reg + GW'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.req0_ready = ready_vec[0];
  assign bus.req1_ready = ready_vec[1];
  assign bus.ser_out    = shift_reg[WIDTH-1];
  assign bus.ser_valid  = ser_valid_reg;
  assign bus.ser_owner  = owner_reg;
  assign bus.frame_done = done_reg & ~flush;

  a_no_done_on_flush: assert property (@(posedge clk) disable iff (!rst_n)
    !(flush && bus.frame_done));
  a_single_grant: assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(ready_vec));

endmodule
